// File: rtl/test_incr_pipe.sv
// Two-stage capture-and-increment pipeline with valid/ready backpressure,
// wrap/saturate arithmetic, sticky per-lane overflow flags and a transfer counter.
module test_incr_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       ovf_flags,
  input  logic                      ovf_clear,
  output logic [15:0]               xfer_count
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic                      s1_valid;
  logic [CHANNELS*WIDTH-1:0] s1_data;
  logic                      s2_valid;
  logic                      s2_accept;
  logic                      s1_advance;
  logic                      in_fire;
  logic                      out_fire;
  logic [CHANNELS*WIDTH-1:0] result;
  logic [CHANNELS-1:0]       carry;

  // Stage 2 can take a new word when empty or when its current word leaves.
  assign s2_accept  = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_accept;
  assign in_ready   = !rst && (!s1_valid || s2_accept);
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = s2_valid;
  assign out_fire   = s2_valid && out_ready;

  // Carry is taken from a WIDTH+1 bit sum so it is independent of the mode.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [WIDTH:0] sum;
    assign sum      = {1'b0, s1_data[i*WIDTH +: WIDTH]} + STEP_EXT;
    assign carry[i] = sum[WIDTH];
    assign result[i*WIDTH +: WIDTH] =
      (SATURATE != 0 && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process ordering cannot change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s1_advance) begin
      s2_valid <= 1'b1;
      out_data <= result;
    end else if (s2_accept) begin
      s2_valid <= 1'b0;
    end
  end

  // A lane overflowing on the same edge as ovf_clear keeps its flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flags <= '0;
    end else begin
      ovf_flags <= (ovf_clear ? '0 : ovf_flags) | (s1_advance ? carry : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (out_fire) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_test_incr_pipe.sv
// Scoreboard bench: instance 0 wraps with STEP=1, instance 1 saturates with STEP=5.
module tb_test_incr_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [31:0] in_data    [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [31:0] out_data   [2];
  logic [3:0]  ovf_flags  [2];
  logic        ovf_clear  [2];
  logic [15:0] xfer_count [2];

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        held      [2];
  logic [31:0] held_data [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  test_incr_pipe #(.WIDTH(8), .CHANNELS(4), .STEP(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .ovf_flags(ovf_flags[0]), .ovf_clear(ovf_clear[0]), .xfer_count(xfer_count[0])
  );

  test_incr_pipe #(.WIDTH(8), .CHANNELS(4), .STEP(5), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .ovf_flags(ovf_flags[1]), .ovf_clear(ovf_clear[1]), .xfer_count(xfer_count[1])
  );

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled output stays put until it is taken.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      if (rst) begin
        held[i] = 1'b0;
        continue;
      end
      if (held[i]) begin
        check(out_valid[i] == 1'b1, "hold_valid", 32'(out_valid[i]), 32'd1);
        check(out_data[i] == held_data[i], "hold_data", out_data[i], held_data[i]);
      end
      if (out_valid[i] && out_ready[i]) begin
        if (q_size(i) == 0) begin
          check(1'b0, "unexpected_output", out_data[i], 32'h0);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check(out_data[i] == e, (i == 0) ? "out_data_wrap" : "out_data_sat",
                out_data[i], e);
        end
      end
      held[i]      = out_valid[i] && !out_ready[i];
      held_data[i] = out_data[i];
    end
  end

  task automatic send(input int i, input logic [31:0] d, input logic [31:0] e);
    int n = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    @(negedge clk);
    while (!in_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) begin
      check(1'b0, "send_timeout", 32'(in_ready[i]), 32'd1);
      in_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      #1 in_valid[i] = 1'b0;
    end
  endtask

  task automatic drain(input int i);
    int n = 0;
    while (q_size(i) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(q_size(i) == 0, "drain_timeout", 32'(q_size(i)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
      ovf_clear[i] = 1'b0;
      held[i]      = 1'b0;
      held_data[i] = '0;
    end

    // Reset state
    #12;
    for (int i = 0; i < 2; i++) begin
      check(in_ready[i] == 1'b0, "rst_in_ready", 32'(in_ready[i]), 32'd0);
      check(out_valid[i] == 1'b0, "rst_out_valid", 32'(out_valid[i]), 32'd0);
      check(out_data[i] == 32'h0, "rst_out_data", out_data[i], 32'h0);
      check(ovf_flags[i] == 4'h0, "rst_ovf", 32'(ovf_flags[i]), 32'h0);
      check(xfer_count[i] == 16'h0, "rst_xfer", 32'(xfer_count[i]), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word, latency 2
    send(0, 32'h03020100, 32'h04030201);
    @(negedge clk);
    check(out_valid[0] == 1'b0, "lat_edge1", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check(out_valid[0] == 1'b1, "lat_edge2", 32'(out_valid[0]), 32'd1);
    drain(0);
    check(xfer_count[0] == 16'd1, "single_xfer", 32'(xfer_count[0]), 32'd1);
    check(ovf_flags[0] == 4'h0, "single_ovf", 32'(ovf_flags[0]), 32'h0);

    // Wrap overflow on lane 2, sticky until cleared
    send(0, 32'h10FF1010, 32'h11001111);
    drain(0);
    check(ovf_flags[0] == 4'b0100, "wrap_ovf", 32'(ovf_flags[0]), 32'h4);
    send(0, 32'h00000000, 32'h01010101);
    drain(0);
    check(ovf_flags[0] == 4'b0100, "wrap_sticky", 32'(ovf_flags[0]), 32'h4);
    ovf_clear[0] = 1'b1;
    @(posedge clk);
    #1 ovf_clear[0] = 1'b0;
    check(ovf_flags[0] == 4'b0000, "wrap_clear", 32'(ovf_flags[0]), 32'h0);
    check(xfer_count[0] == 16'd3, "wrap_xfer", 32'(xfer_count[0]), 32'd3);

    // Saturating instance, STEP=5
    send(1, 32'h000000FC, 32'h050505FF);
    drain(1);
    check(ovf_flags[1] == 4'b0001, "sat_ovf", 32'(ovf_flags[1]), 32'h1);
    send(1, 32'h000000FA, 32'h050505FF);
    drain(1);
    check(ovf_flags[1] == 4'b0001, "sat_no_carry", 32'(ovf_flags[1]), 32'h1);
    send(1, 32'h00000010, 32'h05050515);
    drain(1);
    check(xfer_count[1] == 16'd3, "sat_xfer", 32'(xfer_count[1]), 32'd3);

    // Backpressure: five stalled edges in the middle of an 8-word stream
    fork
      begin
        for (int v = 1; v <= 8; v++)
          send(0, 32'(v), 32'h01010100 | 32'(v + 1));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready[0] = 1'b0;
        repeat (4) @(negedge clk);
        check(in_ready[0] == 1'b0, "bp_in_ready", 32'(in_ready[0]), 32'd0);
        check(q_size(0) == 2, "bp_inflight", 32'(q_size(0)), 32'd2);
        repeat (2) @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    drain(0);
    check(xfer_count[0] == 16'd11, "bp_xfer", 32'(xfer_count[0]), 32'd11);

    // Set/clear collision on lane 1
    send(0, 32'hFFFF00FF, 32'h00000100);
    drain(0);
    check(ovf_flags[0] == 4'b1101, "coll_preset", 32'(ovf_flags[0]), 32'hD);
    send(0, 32'h0000FF00, 32'h01010001);
    ovf_clear[0] = 1'b1;
    @(posedge clk);
    #1 ovf_clear[0] = 1'b0;
    check(ovf_flags[0] == 4'b0010, "coll_set_wins", 32'(ovf_flags[0]), 32'h2);
    drain(0);
    check(xfer_count[0] == 16'd13, "coll_xfer", 32'(xfer_count[0]), 32'd13);

    // Asynchronous reset with a word stalled at the output
    out_ready[0] = 1'b0;
    send(0, 32'h00000005, 32'h01010106);
    repeat (2) @(negedge clk);
    check(out_valid[0] == 1'b1, "pre_rst_valid", 32'(out_valid[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check(out_valid[0] == 1'b0, "arst_out_valid", 32'(out_valid[0]), 32'd0);
    check(ovf_flags[0] == 4'h0, "arst_ovf", 32'(ovf_flags[0]), 32'h0);
    check(xfer_count[0] == 16'h0, "arst_xfer", 32'(xfer_count[0]), 32'h0);
    check(xfer_count[1] == 16'h0, "arst_xfer_sat", 32'(xfer_count[1]), 32'h0);
    check(in_ready[0] == 1'b0, "arst_in_ready", 32'(in_ready[0]), 32'd0);
    exp_q0.delete();
    out_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 32'h00000007, 32'h01010108);
    @(negedge clk);
    check(out_valid[0] == 1'b0, "post_rst_edge1", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check(out_valid[0] == 1'b1, "post_rst_edge2", 32'(out_valid[0]), 32'd1);
    drain(0);
    check(xfer_count[0] == 16'd1, "post_rst_xfer", 32'(xfer_count[0]), 32'd1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_incr_pipe.md
Name: test_incr_pipe

Overview:
Parametrised multi-channel capture-and-increment pipeline. Each channel registers its input word, adds a fixed step, and registers the result. The block runs behind a valid/ready handshake with full backpressure. It provides selectable wrap or saturate arithmetic, sticky per-channel overflow flags and a transfer counter. It is used as a self-checking FF/timing test stage between test stimulus sources and sinks.

Parameters:
WIDTH, 8, bit width of each channel word (>=1)
CHANNELS, 4, number of independent lanes processed in lock-step (>=1)
STEP, 1, unsigned increment added to every lane (0 <= STEP < 2^WIDTH)
SATURATE, 0, 0 = wrap on overflow, 1 = clamp result to all-ones

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data valid this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  CHANNELS*WIDTH  packed lanes, lane i at bits [i*WIDTH +: WIDTH]
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data
out_data  output  CHANNELS*WIDTH  incremented lanes, same packing
ovf_flags  output  CHANNELS  sticky per-lane overflow indicator
ovf_clear  input  1  synchronous clear of all ovf_flags
xfer_count  output  16  number of completed output transfers

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, ovf_flags=0, xfer_count=0, internal capture register=0.
- in_ready is forced 0 while rst is high.
- Stage 1 (capture): on in_valid && in_ready, register in_data into s1_data and set s1_valid=1.
- Stage 2 (result): per lane, sum = {1'b0, s1_lane} + STEP, computed in WIDTH+1 bits; carry = sum[WIDTH].
  - Result = sum[WIDTH-1:0] when SATURATE=0.
  - Result = all-ones when SATURATE=1 and carry=1.
- s2_accept = !s2_valid || out_ready. On s1_valid && s2_accept, load result into out_data and set s2_valid=1.
- If s2_accept && !s1_valid, s2_valid clears on out_ready.
- in_ready = !s1_valid || s2_accept. This is combinational from state and out_ready; no combinational path from in_valid.
- s1_valid clears when s1 advances and no new input is accepted. A simultaneous advance and accept keeps s1_valid=1 with the new data.
- Latency: 2 cycles from input handshake to out_valid, with no stall. Throughput is 1 word/cycle while out_ready=1.
- Hold rule: while out_valid && !out_ready, out_data and out_valid are held stable. s1 fills once, then in_ready=0. No data is lost or duplicated.
- Overflow:
  - ovf_flags[i] is set when lane i's result with carry=1 loads into stage 2, in both wrap and saturate modes.
  - ovf_clear clears all flags next edge.
  - Simultaneous set and clear on the same lane: set wins.
- xfer_count increments on out_valid && out_ready and wraps 65535 -> 0.
- STEP=0: pass-through with latency 2; never overflows.
- Reset mid-operation: all in-flight words are discarded immediately (async). out_valid drops without waiting for a clock edge. No partial transfer is counted.

Test Plan:
- Reset then single word: WIDTH=8, CHANNELS=4, STEP=1, in_data=0x03020100 for one cycle -> out_valid rises 2 cycles later with out_data=0x04030201; xfer_count=1 after out_ready handshake; ovf_flags=0.
- Wrap overflow: SATURATE=0, lane 2 = 0xFF, other lanes 0x10 -> lane 2 out 0x00, others 0x11; ovf_flags=4'b0100 and stays set; ovf_clear pulse -> 0.
- Saturate overflow: SATURATE=1, STEP=5, lane 0 = 0xFC -> lane 0 out 0xFF, ovf_flags[0]=1; lane 0 = 0xFA -> 0xFF, no new flag needed (already set); lane 0 = 0x10 -> 0x15.
- Backpressure: stream 0x01..0x08 (lane 0) with out_ready low for 5 cycles mid-stream -> in_ready drops after 2 accepted-but-unsent words; out_data held stable; outputs are exactly 0x02..0x09 in order; xfer_count=8.
- Set/clear collision: ovf_clear high in the same cycle lane 1 overflows -> ovf_flags[1]=1 next cycle; other lanes cleared.
- Async reset mid-stream: assert rst between clock edges with out_valid=1 -> out_valid, ovf_flags and xfer_count go 0 before the next clk edge; after release, the first new word emerges 2 cycles after acceptance.
